instr_encoder: RTL and testbench

Instruction encoder and loader for the single-cycle MIPS core. It performs the inverse of the instruction decoder: it takes field-level instruction requests (operation, rs, rt, rd, immediate) over a valid/ready handshake and assembles legal 32-bit MIPS words. It writes each word sequentially into the instruction-memory write port. It sits between the bench/boot host and instruction memory, and loads programs before the core is released from reset.

---
 rtl/instr_encoder_pkg.sv | 29 ++
 rtl/instr_encoder_field_pack.sv | 40 ++++
 rtl/instr_encoder.sv | 163 ++++++++++++++++
 tb/tb_instr_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared MIPS opcode/funct constants, request selector codes and encoder state encoding.
package instr_encoder_pkg;

    localparam logic [5:0] OPC_R_TYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI   = 6'b001000;
    localparam logic [5:0] OPC_ANDI   = 6'b001100;
    localparam logic [5:0] OPC_ORI    = 6'b001101;
    localparam logic [5:0] OPC_XORI   = 6'b001110;
    localparam logic [5:0] OPC_SLTI   = 6'b001010;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;

    typedef enum logic [2:0] {
        SEL_ADD  = 3'd0,
        SEL_ADDI = 3'd1,
        SEL_ANDI = 3'd2,
        SEL_ORI  = 3'd3,
        SEL_XORI = 3'd4,
        SEL_SLTI = 3'd5
    } op_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_PAD    = 3'd3,
        ST_DONE   = 3'd4
    } enc_state_e;

endpackage

// File: rtl/instr_encoder_field_pack.sv
// instr_field_pack: combinational pack of op/rs/rt/rd/imm into a MIPS word.
// Unknown selector codes raise invalid and yield an all-zero word.
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        invalid
);

    logic [5:0] opcode;

    always_comb begin
        invalid = 1'b0;
        opcode  = OPC_R_TYPE;
        case (op_sel_e'(op))
            SEL_ADD:  opcode = OPC_R_TYPE;
            SEL_ADDI: opcode = OPC_ADDI;
            SEL_ANDI: opcode = OPC_ANDI;
            SEL_ORI:  opcode = OPC_ORI;
            SEL_XORI: opcode = OPC_XORI;
            SEL_SLTI: opcode = OPC_SLTI;
            default:  invalid = 1'b1;
        endcase

        // Immediate is passed through raw; sign/zero extension is the core's job.
        if (invalid) begin
            word = 32'h0000_0000;
        end else if (op == SEL_ADD) begin
            word = {OPC_R_TYPE, rs, rt, rd, 5'b00000, FUNCT_ADD};
        end else begin
            word = {opcode, rs, rt, imm};
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs field requests into MIPS words and loads instruction memory (NOP fill: INSTR_ENC_NOP_PAD_EN).
// Latency: accept at edge N, im_we high during N+1, in_ready back in N+2; one word per 2 cycles.
// Backpressure: in_ready only in ACCEPT; low during the write cycle and outside a session.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err_op,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              err_op_q, err_op_d;
    logic              last_q, last_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;

    logic [31:0]       pack_word;
    logic              pack_invalid;

    instr_field_pack u_pack (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .word    (pack_word),
        .invalid (pack_invalid)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        full_d     = full_q;
        err_op_d   = err_op_q;
        last_d     = last_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_ACCEPT;
                    ptr_d    = '0;
                    count_d  = '0;
                    full_d   = 1'b0;
                    err_op_d = 1'b0;
                end
            end
            ST_ACCEPT: begin
                if (in_valid) begin
                    if (pack_invalid) begin
                        err_op_d = 1'b1;
                        if (in_last) state_d = ST_DONE;
                    end else begin
                        // The im_* registers double as the holding register for the write cycle.
                        im_we_d    = 1'b1;
                        im_addr_d  = ptr_q;
                        im_wdata_d = pack_word;
                        last_d     = in_last;
                        state_d    = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                count_d = count_q + 1'b1;
                if (ptr_q == PTR_MAX) begin
                    full_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                    if (!last_q) begin
                        state_d = ST_ACCEPT;
                    end else begin
`ifdef INSTR_ENC_NOP_PAD_EN
                        state_d    = ST_PAD;
                        im_we_d    = 1'b1;
                        im_addr_d  = ptr_q + 1'b1;
                        im_wdata_d = 32'h0000_0000;
`else
                        state_d    = ST_DONE;
`endif
                    end
                end
            end
`ifdef INSTR_ENC_NOP_PAD_EN
            ST_PAD: begin
                // ptr_q tracks the address being written this cycle.
                if (ptr_q == PTR_MAX) begin
                    full_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ptr_d     = ptr_q + 1'b1;
                    im_we_d   = 1'b1;
                    im_addr_d = ptr_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            err_op_q   <= 1'b0;
            last_q     <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            err_op_q   <= err_op_d;
            last_q     <= last_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
        end
    end

    assign in_ready = (state_q == ST_ACCEPT);
    assign busy     = (state_q == ST_ACCEPT) || (state_q == ST_WRITE) || (state_q == ST_PAD);
    assign done     = (state_q == ST_DONE);
    assign full     = full_q;
    assign err_op   = err_op_q;
    assign count    = count_q;
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: scoreboard of expected memory writes fed by a field-level model.
module tb_instr_encoder;
    localparam int AW   = 4;
    localparam int MAXA = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0]   in_imm = '0;
    logic          in_last = 1'b0;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          busy, done, full, err_op;
    logic [AW:0]   count;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .busy(busy), .done(done), .full(full), .err_op(err_op), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] seen [0:MAXA];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Session model
    int m_ptr = 0, m_count = 0;
    bit m_full = 0, m_err = 0, m_open = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                             input int rd, input int imm);
        int          opc_tab [6];
        logic [31:0] w;
        opc_tab = '{0, 8, 12, 13, 14, 10};
        w = (32'(opc_tab[op]) << 26) | (32'(rs) << 21) | (32'(rt) << 16);
        if (op == 0) w = w | (32'(rd) << 11) | 32'd32;
        else         w = w | 32'(imm);
        return w;
    endfunction

    task automatic push_exp(input int addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr[AW-1:0];
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic model_accept(input int op, input int rs, input int rt, input int rd,
                                input int imm, input bit last);
        if (op > 5) begin
            m_err = 1;
            if (last) m_open = 0;
        end else begin
            push_exp(m_ptr, ref_word(op, rs, rt, rd, imm));
            m_count++;
            if (m_ptr == MAXA) begin
                m_full = 1;
                m_open = 0;
            end else begin
                m_ptr++;
                if (last) begin
                    m_open = 0;
`ifdef INSTR_ENC_NOP_PAD_EN
                    while (m_ptr <= MAXA) begin
                        push_exp(m_ptr, 32'h0);
                        m_ptr++;
                    end
                    m_full = 1;
`endif
                end
            end
        end
    endtask

    // Monitor: every memory write must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (im_we === 1'b1) begin
            seen[im_addr] = im_wdata;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         im_addr, im_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(im_addr), 64'(e.addr));
                check("wr_data", 64'(im_wdata), 64'(e.data));
            end
        end
    end

    task automatic send(input int op, input int rs, input int rt, input int rd,
                        input int imm, input bit last);
        int n;
        bit acc;
        @(negedge clk);
        in_op = 3'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = 16'(imm); in_last = last; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        acc = (in_ready === 1'b1);
        check("accept", 64'(acc), 64'(m_open));
        if (acc) begin
            model_accept(op, rs, rt, rd, imm, last);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic start_session();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_ptr = 0; m_count = 0; m_full = 0; m_err = 0; m_open = 1;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic finish_session();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 4 * (MAXA + 1) + 20) begin
            @(negedge clk);
            n++;
        end
        check("done", 64'(done), 64'd1);
        check("count", 64'(count), 64'(m_count));
        check("full", 64'(full), 64'(m_full));
        check("err_op", 64'(err_op), 64'(m_err));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_im_we"},    64'(im_we), 64'd0);
        check({tag, "_im_addr"},  64'(im_addr), 64'd0);
        check({tag, "_im_wdata"}, 64'(im_wdata), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_busy"},     64'(busy), 64'd0);
        check({tag, "_done"},     64'(done), 64'd0);
        check({tag, "_full"},     64'(full), 64'd0);
        check({tag, "_err_op"},   64'(err_op), 64'd0);
        check({tag, "_count"},    64'(count), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Single ADDI with last
        start_session();
        send(1, 1, 2, 0, 16'h0005, 1);
        finish_session();
        check("tp_addi_word", 64'(seen[0]), 64'h2022_0005);

        // ADD then ORI with last
        start_session();
        send(0, 1, 2, 3, 16'h1234, 0);
        send(3, 0, 4, 0, 16'hFFFF, 1);
        finish_session();
        check("tp_add_word", 64'(seen[0]), 64'h0022_1820);
        check("tp_ori_word", 64'(seen[1]), 64'h3404_FFFF);

        // Invalid op mid-stream, plus a start pulse that must be ignored
        start_session();
        send(1, 3, 4, 0, 16'h0010, 0);
        send(7, 9, 9, 9, 16'hDEAD, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(4, 5, 6, 0, 16'h00AA, 1);
        finish_session();
        check("tp_xori_word", 64'(seen[1]), 64'h38A6_00AA);

        // Fill to capacity; the extra request must stall
        start_session();
        for (int i = 0; i <= MAXA + 1; i++) begin
            send($urandom_range(0, 5), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 65535), (i == MAXA));
        end
        finish_session();

        // Reset during the write cycle aborts the session
        start_session();
        send(2, 7, 8, 0, 16'h0F0F, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_open = 0;
        @(negedge clk);
        check_all_zero("abort");
        repeat (3) @(negedge clk);
        start_session();
        send(5, 10, 11, 0, 16'h8001, 1);
        finish_session();
        check("restart_word", 64'(seen[0]), 64'h294B_8001);

        // Random sessions
        for (int s = 0; s < 8; s++) begin
            int len;
            len = $urandom_range(1, 6);
            start_session();
            for (int i = 0; i < len; i++) begin
                if (m_open) begin
                    send($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 31), $urandom_range(0, 65535), (i == len - 1));
                end
            end
            finish_session();
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
